// File: rtl/rs485_uart_receiver_pkg.sv
// rs485_uart_receiver_pkg: shared UART defaults, FSM state encoding and mid-bit helper
package rs485_uart_receiver_pkg;
  localparam int DEF_CLKS_PER_BIT = 50;
  localparam int DEF_IDLE_BITS = 12;
  localparam int DEF_ERR_CNT_W = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;
  // Sample point at the middle of a bit period.
  function automatic int mid_of(input int cpb);
    return cpb / 2;
  endfunction
endpackage

// File: rtl/rs485_uart_receiver_if.sv
// rs485_uart_receiver_if: serial line in, byte/error/idle strobes out
//  master: line driver and byte consumer; slave: the receiver
interface rs485_uart_receiver_if #(parameter int ERR_CNT_W = 8);
  logic                 rx_i;
  logic                 rx_data_ready;
  logic [7:0]           rx_data;
  logic                 framing_error;
  logic                 rx_break;
  logic                 rx_idle;
  logic [ERR_CNT_W-1:0] err_count;
  modport master (output rx_i, input rx_data_ready, rx_data, framing_error, rx_break, rx_idle, err_count);
  modport slave (input rx_i, output rx_data_ready, rx_data, framing_error, rx_break, rx_idle, err_count);
endinterface

// File: rtl/rs485_uart_receiver_sampler.sv
// rs485_uart_receiver_sampler: 2-FF synchroniser, bit-period counter and 3-sample majority vote
//  CLK, reset_n  clock, async active-low reset
//  rx_i          raw line; align_i restarts the bit counter at a start edge
//  rx_s_o        synchronised line; vote_o/vote_valid_o majority at cnt=MID+1; bit_end_o at cnt wrap
module rs485_uart_receiver_sampler
  import rs485_uart_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic rx_i,
  input  logic align_i,
  output logic rx_s_o,
  output logic vote_o,
  output logic vote_valid_o,
  output logic bit_end_o
);
  localparam int MID = mid_of(CLKS_PER_BIT);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [1:0]    sync_q;
  logic [1:0]    smp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  assign rx_s_o = sync_q[1];
  assign bit_end_o = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign vote_valid_o = cnt_q == CW'(MID + 1);
  // Samples at MID-1 and MID are stored; the MID+1 sample is the live line.
  assign vote_o = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s_o) | (smp_q[0] & rx_s_o);
  assign cnt_d = (align_i || bit_end_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      smp_q  <= 2'b11;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      cnt_q  <= cnt_d;
      if (cnt_q == CW'(MID - 1) || cnt_q == CW'(MID)) smp_q <= {smp_q[0], rx_s_o};
    end
  end
endmodule

// File: rtl/rs485_uart_receiver.sv
// rs485_uart_receiver: 8N1 RS485 byte receiver with framing-error, break and bus-idle strobes
//  CLK, reset_n  clock, async active-low reset
//  bus           rx_i in; rx_data_ready/rx_data, framing_error, rx_break, rx_idle, err_count out
module rs485_uart_receiver
  import rs485_uart_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int IDLE_BITS    = DEF_IDLE_BITS,
  parameter int ERR_CNT_W    = DEF_ERR_CNT_W
) (
  input logic CLK,
  input logic reset_n,
  rs485_uart_receiver_if.slave bus
);
  localparam int ILIM = IDLE_BITS * CLKS_PER_BIT;
  localparam int ICW = $clog2(ILIM);
  state_e               state_q, state_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [7:0]           data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 idle_q, idle_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [ICW-1:0]       icnt_q, icnt_d;
  logic                 rx_s, vote, vote_valid, bit_end;
  rs485_uart_receiver_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .rx_i        (bus.rx_i),
    .align_i     (state_q == IDLE && !rx_s),
    .rx_s_o      (rx_s),
    .vote_o      (vote),
    .vote_valid_o(vote_valid),
    .bit_end_o   (bit_end)
  );
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    rdy_d     = 1'b0;
    ferr_d    = 1'b0;
    brk_d     = 1'b0;
    err_d     = err_q;
    case (state_q)
      IDLE: if (!rx_s) state_d = START;
      START: begin
        if (vote_valid && vote) state_d = IDLE;
        else if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (vote_valid) shreg_d[bit_idx_q] = vote;
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      // Decide at mid-stop so a following start edge is never missed.
      STOP: begin
        if (vote_valid && vote) begin
          data_d  = shreg_q;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else if (vote_valid) begin
          ferr_d  = 1'b1;
          brk_d   = shreg_q == 8'h00;
          err_d   = &err_q ? err_q : err_q + 1'b1;
          state_d = WAIT_HIGH;
        end
      end
      // A held-low line must not be re-read as a stream of start bits.
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Idle counter saturates at ILIM-1 so rx_idle fires once per quiet period.
  assign icnt_d = !rx_s ? '0 : (state_q == IDLE && icnt_q != ICW'(ILIM - 1)) ? icnt_q + 1'b1 : icnt_q;
  assign idle_d = rx_s && state_q == IDLE && icnt_q == ICW'(ILIM - 2);
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      idle_q    <= 1'b0;
      err_q     <= '0;
      icnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      icnt_q    <= icnt_d;
    end
  end
  assign bus.rx_data_ready = rdy_q;
  assign bus.rx_data       = data_q;
  assign bus.framing_error = ferr_q;
  assign bus.rx_break      = brk_q;
  assign bus.rx_idle       = idle_q;
  assign bus.err_count     = err_q;
endmodule

// File: tb/tb_rs485_uart_receiver.sv
// tb_rs485_uart_receiver: scoreboard bench for rs485_uart_receiver with directed byte frames
`timescale 1ns/1ps
module tb_rs485_uart_receiver;
  localparam int CPB = 16;
  localparam int IDLE_BITS = 12;
  localparam int EW = 8;
  localparam int LAT = 9 * CPB + CPB / 2 + 4;
  localparam real BIT = CPB * 10.0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int n_idle = 0;
  int rdy_cyc = 0;
  logic [9:0] exp_q[$];
  rs485_uart_receiver_if #(.ERR_CNT_W(EW)) bus ();
  rs485_uart_receiver #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IDLE_BITS), .ERR_CNT_W(EW)) dut (
    .CLK    (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: every byte/error strobe pops one expected event {ferr, brk, data}.
  always @(negedge clk) begin
    logic [9:0] act, exp_v;
    if (bus.rx_idle) n_idle++;
    if (bus.rx_data_ready) rdy_cyc = cyc;
    if (bus.rx_data_ready || bus.framing_error || bus.rx_break) begin
      act = {bus.framing_error, bus.rx_break, bus.framing_error ? 8'h00 : bus.rx_data};
      n_cmp++;
      if (int'(bus.rx_data_ready) + int'(bus.framing_error) + int'(bus.rx_idle) > 1 || (bus.rx_break && !bus.framing_error)) begin
        n_fail++;
        $display("FAIL exclusive: rdy=%b ferr=%b brk=%b idle=%b", bus.rx_data_ready, bus.framing_error, bus.rx_break, bus.rx_idle);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected strobe: got %h, none required", act);
      end else begin
        exp_v = exp_q.pop_front();
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL event: got %h required %h", act, exp_v);
        end
      end
    end
  end
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp_v);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop, input real bt);
    bus.rx_i = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      bus.rx_i = b[i];
      #(bt);
    end
    bus.rx_i = stop;
    #(bt);
    bus.rx_i = 1'b1;
  endtask
  task automatic drain(input int max_cyc);
    int t = 0;
    while (exp_q.size() != 0 && t < max_cyc) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d events still pending", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " rdy"}, 32'(bus.rx_data_ready), 0);
    chk({nm, " data"}, 32'(bus.rx_data), 0);
    chk({nm, " ferr"}, 32'(bus.framing_error), 0);
    chk({nm, " brk"}, 32'(bus.rx_break), 0);
    chk({nm, " idle"}, 32'(bus.rx_idle), 0);
    chk({nm, " err"}, 32'(bus.err_count), 0);
  endtask
  initial begin
    int d0, i0;
    logic [7:0] sweep [3];
    real scl [2];
    sweep = '{8'h00, 8'hFF, 8'h81};
    scl = '{1.03, 0.97};
    bus.rx_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;
    repeat (IDLE_BITS * CPB + 60) @(posedge clk);
    chk("idle after reset", 32'(n_idle), 1);
    // 1: single byte, exact latency from first low-sampling edge
    @(posedge clk);
    #1 d0 = cyc;
    exp_q.push_back({2'b00, 8'hA5});
    send_byte(8'hA5, 1'b1, BIT);
    drain(100);
    chk("latency", 32'(rdy_cyc - (d0 + 1)), 32'(LAT));
    chk("data A5", 32'(bus.rx_data), 32'h A5);
    // 2: back-to-back bytes with a single stop bit
    foreach (sweep[i]) ;
    exp_q.push_back({2'b00, 8'h1C});
    exp_q.push_back({2'b00, 8'hE1});
    exp_q.push_back({2'b00, 8'hCE});
    exp_q.push_back({2'b00, 8'hBB});
    send_byte(8'h1C, 1'b1, BIT);
    send_byte(8'hE1, 1'b1, BIT);
    send_byte(8'hCE, 1'b1, BIT);
    send_byte(8'hBB, 1'b1, BIT);
    drain(100);
    chk("err after b2b", 32'(bus.err_count), 0);
    // 3: short low glitch is rejected, next byte still received
    #(BIT);
    bus.rx_i = 1'b0;
    #50;
    bus.rx_i = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    exp_q.push_back({2'b00, 8'h3C});
    send_byte(8'h3C, 1'b1, BIT);
    drain(100);
    chk("data 3C", 32'(bus.rx_data), 32'h3C);
    // 4: stop bit low -> framing error, data held
    #(BIT);
    exp_q.push_back({2'b10, 8'h00});
    send_byte(8'h55, 1'b0, BIT);
    drain(100);
    chk("err after ferr", 32'(bus.err_count), 1);
    chk("data held", 32'(bus.rx_data), 32'h3C);
    // 5: line held low -> one break, then a single idle pulse after release
    #(2 * BIT);
    exp_q.push_back({2'b11, 8'h00});
    bus.rx_i = 1'b0;
    #(20 * BIT);
    drain(10);
    bus.rx_i = 1'b1;
    i0 = n_idle;
    repeat (IDLE_BITS * CPB + 20) @(posedge clk);
    chk("idle after break", 32'(n_idle - i0), 1);
    repeat (2 * IDLE_BITS * CPB) @(posedge clk);
    chk("idle no repulse", 32'(n_idle - i0), 1);
    chk("err after break", 32'(bus.err_count), 2);
    // 6: +/-3% baud sweep
    foreach (scl[s]) begin
      foreach (sweep[i]) begin
        exp_q.push_back({2'b00, sweep[i]});
        send_byte(sweep[i], 1'b1, BIT * scl[s]);
        #(BIT);
        drain(100);
      end
    end
    chk("data 81", 32'(bus.rx_data), 32'h81);
    // error counter saturation
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({2'b10, 8'h00});
      send_byte(8'h55, 1'b0, BIT);
      #(2 * BIT);
    end
    drain(100);
    chk("err saturate", 32'(bus.err_count), 32'hFF);
    // reset in the middle of a byte
    fork
      send_byte(8'h00, 1'b1, BIT);
      begin
        #(4 * BIT);
        rst_n = 1'b0;
        #25;
        chk_zero("mid reset");
      end
    join
    #(2 * BIT);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3 * CPB * 10) @(posedge clk);
    chk("err after reset", 32'(bus.err_count), 0);
    chk("data after reset", 32'(bus.rx_data), 0);
    chk("queue empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
